// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: function-select codes, flag bit
// positions and the register-file writeback entry layout.
package alu_pkg;

    localparam logic [4:0] ADDU = 5'h03;
    localparam logic [4:0] SUBU = 5'h05;
    localparam logic [4:0] MUL  = 5'h1E;
    localparam logic [4:0] DIV  = 5'h1F;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam int WB_DEPTH = 2;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    // MUL and DIV produce a 64-bit product/quotient that lands in HI/LO
    function automatic logic is_hilo_op(input logic [4:0] fs);
        return (fs == MUL) || (fs == DIV);
    endfunction

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic v, input logic c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_capture_if.sv
// ALU result handshake bundle: the ALU is the master, the capture block the slave.
interface alu_result_capture_if;
    import alu_pkg::*;

    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  FS;
    logic [31:0] Y_Hi;
    logic [31:0] Y_Low;
    logic        N;
    logic        Z;
    logic        V;
    logic        C;
    logic [4:0]  dest;

    modport master (
        output alu_valid, FS, Y_Hi, Y_Low, N, Z, V, C, dest,
        input  alu_ready
    );

    modport slave (
        input  alu_valid, FS, Y_Hi, Y_Low, N, Z, V, C, dest,
        output alu_ready
    );

endinterface

// File: rtl/alu_result_capture_wb_fifo2.sv
// Two-entry valid/ready FIFO of writeback entries; head is presented combinationally
// from the slot selected by the registered read pointer.
module wb_fifo2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  wb_entry_t  push_entry,
    output logic       can_push,
    output logic       head_valid,
    output wb_entry_t  head_entry,
    input  logic       pop_ready,
    output logic [1:0] count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       push_ok;
    logic       pop_ok;

    assign can_push   = (count_reg != 2'(WB_DEPTH));
    assign head_valid = (count_reg != 2'd0);
    assign push_ok    = push & can_push;
    assign pop_ok     = head_valid & pop_ready;
    assign count      = count_reg;

    // Data slots carry no reset: their contents only matter once count says so
    genvar gi;
    generate
        for (gi = 0; gi < WB_DEPTH; gi++) begin : g_slot
            wb_entry_t slot_reg;
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= push_entry;
                end
            end
        end
    endgenerate

    assign head_entry = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg ^ push_ok;
            rd_ptr_reg <= rd_ptr_reg ^ pop_ok;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/alu_result_capture.sv
// Receiving end of the ALU result interface: captures HI/LO for MUL/DIV, queues
// register-file writes, and holds the flag register and sticky overflow bit.
module alu_result_capture
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    alu_result_capture_if.slave  alu,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [4:0]           wb_addr,
    output logic [31:0]          wb_data,
    output logic [31:0]          HI,
    output logic [31:0]          LO,
    output logic [3:0]           flags,
    output logic                 ovf_sticky,
    input  logic                 clr_sticky,
    output logic [1:0]           pending
);

    logic        acc;
    logic        can_push;
    logic        hilo_op;
    logic        push;
    wb_entry_t   push_entry;
    wb_entry_t   head_entry;

    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [3:0]  flags_reg, flags_next;
    logic        ovf_sticky_reg, ovf_sticky_next;

    // Ready depends only on registered occupancy, so HI/LO results stall while full too
    assign alu.alu_ready = can_push;
    assign acc           = alu.alu_valid & can_push;
    assign hilo_op       = is_hilo_op(alu.FS);
    assign push          = acc & ~hilo_op & (alu.dest != 5'd0);

    assign push_entry.addr = alu.dest;
    assign push_entry.data = alu.Y_Low;

    wb_fifo2 u_wb_fifo2 (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .can_push   (can_push),
        .head_valid (wb_valid),
        .head_entry (head_entry),
        .pop_ready  (wb_ready),
        .count      (pending)
    );

    assign wb_addr = head_entry.addr;
    assign wb_data = head_entry.data;

    always_comb begin
        hi_next         = hi_reg;
        lo_next         = lo_reg;
        flags_next      = flags_reg;
        ovf_sticky_next = (ovf_sticky_reg & ~clr_sticky) | (acc & alu.V);
        if (acc) begin
            flags_next = pack_flags(alu.N, alu.Z, alu.V, alu.C);
            if (hilo_op) begin
                hi_next = alu.Y_Hi;
                lo_next = alu.Y_Low;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg         <= 32'd0;
            lo_reg         <= 32'd0;
            flags_reg      <= 4'b0000;
            ovf_sticky_reg <= 1'b0;
        end else begin
            hi_reg         <= hi_next;
            lo_reg         <= lo_next;
            flags_reg      <= flags_next;
            ovf_sticky_reg <= ovf_sticky_next;
        end
    end

    assign HI         = hi_reg;
    assign LO         = lo_reg;
    assign flags      = flags_reg;
    assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture: HI/LO capture, writeback queueing,
// backpressure, R0 drop, sticky overflow and asynchronous reset.
module tb_alu_result_capture;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [3:0]  flags;
    logic        ovf_sticky;
    logic        clr_sticky;
    logic [1:0]  pending;

    int checks   = 0;
    int failures = 0;

    alu_result_capture_if alu_if ();

    alu_result_capture dut (
        .clk        (clk),
        .reset      (reset),
        .alu        (alu_if),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .HI         (HI),
        .LO         (LO),
        .flags      (flags),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before driving/sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [4:0] fs, input logic [4:0] dst,
                         input logic [31:0] yhi, input logic [31:0] ylo, input logic [3:0] nzvc);
        alu_if.alu_valid = valid;
        alu_if.FS        = fs;
        alu_if.dest      = dst;
        alu_if.Y_Hi      = yhi;
        alu_if.Y_Low     = ylo;
        alu_if.N         = nzvc[3];
        alu_if.Z         = nzvc[2];
        alu_if.V         = nzvc[1];
        alu_if.C         = nzvc[0];
        $display("drive valid=%0b FS=%h dest=%0d Y_Hi=%h Y_Low=%h nzvc=%b wb_ready=%0b clr=%0b",
                 valid, fs, dst, yhi, ylo, nzvc, wb_ready, clr_sticky);
    endtask

    task automatic idle();
        alu_if.alu_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        wb_ready   = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b1, MUL, 5'd7, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1111);
        step();
        step();

        // Reset held with a valid result presented
        check("rst_hi",        HI,         32'd0);
        check("rst_lo",        LO,         32'd0);
        check("rst_flags",     32'(flags), 32'd0);
        check("rst_wb_valid",  32'(wb_valid), 32'd0);
        check("rst_alu_ready", 32'(alu_if.alu_ready), 32'd1);
        check("rst_pending",   32'(pending), 32'd0);
        check("rst_ovf",       32'(ovf_sticky), 32'd0);
        idle();
        reset = 1'b1;
        step();

        // MUL capture
        drive(1'b1, MUL, 5'd5, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0000);
        step();
        idle();
        check("mul_hi",       HI,            32'h0000_0001);
        check("mul_lo",       LO,            32'hFFFF_FFFE);
        check("mul_wb_valid", 32'(wb_valid), 32'd0);
        check("mul_pending",  32'(pending),  32'd0);

        // ADDU writeback with register file ready
        wb_ready = 1'b1;
        drive(1'b1, ADDU, 5'd8, 32'h0, 32'h0000_0010, 4'b0001);
        step();
        idle();
        check("addu_wb_valid", 32'(wb_valid), 32'd1);
        check("addu_wb_addr",  32'(wb_addr),  32'd8);
        check("addu_wb_data",  wb_data,       32'h0000_0010);
        check("addu_flags",    32'(flags),    32'b0001);
        check("addu_hi_keep",  HI,            32'h0000_0001);
        step();
        check("addu_drained",  32'(pending),  32'd0);
        check("addu_wb_low",   32'(wb_valid), 32'd0);

        // Backpressure: fill both entries
        wb_ready = 1'b0;
        drive(1'b1, ADDU, 5'd3, 32'h0, 32'h0000_000A, 4'b0000);
        step();
        drive(1'b1, SUBU, 5'd4, 32'h0, 32'h0000_000B, 4'b0000);
        step();
        idle();
        check("full_pending",   32'(pending), 32'd2);
        check("full_alu_ready", 32'(alu_if.alu_ready), 32'd0);
        check("full_head_addr", 32'(wb_addr), 32'd3);
        check("full_head_data", wb_data,      32'h0000_000A);

        // Third result and a MUL are both held off while full
        drive(1'b1, ADDU, 5'd9, 32'h0, 32'h0000_000C, 4'b1000);
        step();
        check("held_pending",   32'(pending), 32'd2);
        check("held_flags",     32'(flags),   32'b0000);
        drive(1'b1, MUL, 5'd0, 32'h0000_0055, 32'h0000_0066, 4'b0000);
        step();
        idle();
        check("held_mul_hi",    HI,           32'h0000_0001);
        check("held_head_addr", 32'(wb_addr), 32'd3);

        // Drain: 3 leaves first, then 4 is head
        wb_ready = 1'b1;
        step();
        check("drain1_pending", 32'(pending), 32'd1);
        check("drain1_addr",    32'(wb_addr), 32'd4);
        check("drain1_data",    wb_data,      32'h0000_000B);

        // Simultaneous push and pop at pending=1
        drive(1'b1, ADDU, 5'd6, 32'h0, 32'h0000_0066, 4'b0000);
        step();
        idle();
        check("pushpop_pending", 32'(pending), 32'd1);
        check("pushpop_addr",    32'(wb_addr), 32'd6);
        check("pushpop_data",    wb_data,      32'h0000_0066);
        step();
        check("pushpop_empty",   32'(pending), 32'd0);

        // R0 drop: flags update, no push
        drive(1'b1, ADDU, 5'd0, 32'h0, 32'h0000_0077, 4'b0100);
        step();
        idle();
        check("r0_pending",  32'(pending),  32'd0);
        check("r0_wb_valid", 32'(wb_valid), 32'd0);
        check("r0_flags",    32'(flags),    32'b0100);

        // Sticky overflow
        check("ovf_init", 32'(ovf_sticky), 32'd0);
        drive(1'b1, ADDU, 5'd0, 32'h0, 32'h0, 4'b0010);
        step();
        check("ovf_set",       32'(ovf_sticky), 32'd1);
        check("ovf_set_flags", 32'(flags),      32'b0010);
        clr_sticky = 1'b1;
        drive(1'b1, ADDU, 5'd0, 32'h0, 32'h0, 4'b0010);
        step();
        check("ovf_set_beats_clr", 32'(ovf_sticky), 32'd1);
        drive(1'b1, ADDU, 5'd0, 32'h0, 32'h0, 4'b0000);
        step();
        check("ovf_cleared", 32'(ovf_sticky), 32'd0);
        clr_sticky = 1'b0;
        drive(1'b0, ADDU, 5'd0, 32'h0, 32'h0, 4'b0010);
        step();
        check("ovf_no_acc", 32'(ovf_sticky), 32'd0);

        // Asynchronous reset with two queued entries
        wb_ready = 1'b0;
        drive(1'b1, ADDU, 5'd1, 32'h0, 32'h0000_0101, 4'b0000);
        step();
        drive(1'b1, ADDU, 5'd2, 32'h0, 32'h0000_0202, 4'b0000);
        step();
        idle();
        check("pre_rst_pending", 32'(pending), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pending",   32'(pending),  32'd0);
        check("async_rst_wb_valid",  32'(wb_valid), 32'd0);
        check("async_rst_alu_ready", 32'(alu_if.alu_ready), 32'd1);
        check("async_rst_hi",        HI,            32'd0);
        step();
        reset = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_capture.md
# alu_result_capture

Receiving end of the 32-bit ALU result interface. Accepts one ALU result per valid/ready handshake (FS, Y_Hi, Y_Low, N/Z/V/C, destination register), routes MUL/DIV products and quotients into architectural HI/LO registers, and queues all other results in a 2-entry buffer toward the register-file write port. Holds the flag register and a sticky overflow bit for the datapath controller.

## Interface
- `MUL`, 5'h1E: FS code for multiply; writes HI/LO.
- `DIV`, 5'h1F: FS code for divide; writes HI/LO.
- `DEPTH`, 2: writeback buffer entries. Fixed at 2; other values are unsupported.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_ready`  out  1  block can accept; `= (count != 2)`.
- `FS`  in  5  function select of the result.
- `Y_Hi`, `Y_Low`  in  32 each  ALU result halves.
- `N`, `Z`, `V`, `C`  in  1 each  ALU flags.
- `dest`  in  5  destination register number.
- `wb_valid`  out  1  buffer head valid.
- `wb_ready`  in  1  register file accepts the head entry.
- `wb_addr`  out  5  head destination.
- `wb_data`  out  32  head data (Y_Low of the original result).
- `HI`, `LO`  out  32 each  architectural HI/LO.
- `flags`  out  4  {N,Z,V,C} of the last accepted result.
- `ovf_sticky`  out  1  set by any accepted result with V=1.
- `clr_sticky`  in  1  synchronous clear of `ovf_sticky`.
- `pending`  out  2  buffer occupancy (0..2).

## Operation
- Accept: `acc = alu_valid & alu_ready`. Without `acc`, no input is sampled.
- On `acc` with FS==MUL or FS==DIV:
  - `HI <= Y_Hi`, `LO <= Y_Low`.
  - No buffer entry.
- On `acc` with any other FS:
  - dest != 0: push {dest, Y_Low}.
  - dest == 0: result is dropped, with no push. Flags still update.
- On every `acc`: `flags <= {N,Z,V,C}`.
- Sticky overflow:
  - `ovf_sticky <= (ovf_sticky & ~clr_sticky) | (acc & V)`.
  - A set and a clear in the same cycle leave the bit at 1.
- Buffer: circular, 2 entries, 1-bit read/write pointers, 2-bit count.
  - Pop when `wb_valid & wb_ready`.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
  - Pop when empty: impossible, because `wb_valid=0`.
  - Push when full: impossible, because `alu_ready=0`.
- `alu_ready` deasserts while full, including for MUL/DIV results, which are then held off too.
- Outputs `wb_valid = (count!=0)`, `wb_addr`/`wb_data` = head entry. Outputs are stable while `wb_valid & ~wb_ready`.
- Reset (asynchronous assert, released synchronously by the system) sets:
  - HI=LO=0, flags=4'b0000, ovf_sticky=0.
  - Pointers=0, count=0, so wb_valid=0, pending=0, alu_ready=1.
  - Buffer data contents are don't-care.
- Reset mid-operation drops all queued entries. No partial write occurs.

## Timing
- Input-to-HI/LO/flags latency: 1 cycle. Values are visible the cycle after `acc`.
- Input-to-writeback latency: 1 cycle when the buffer is empty. `wb_valid` rises the cycle after `acc`.
- Throughput: 1 result/cycle sustained when `wb_ready` is held high.
- `alu_ready` and `wb_valid` are functions of registered count only. There is no combinational path from `alu_valid` or `wb_ready`.
- Count transitions per cycle:
  - 0→1 on push.
  - 1→2 on push without pop.
  - 2→1 on pop.
  - 1→0 on pop without push.

## Structure
- Shared package `alu_pkg`:
  - FS constants (MUL=5'h1E, DIV=5'h1F, ADDU=5'h03, SUBU=5'h05).
  - Flag index constants (N=3, Z=2, V=1, C=0).
  - Writeback entry type {addr[4:0], data[31:0]}.
- One sub-module, `wb_fifo2`: 2-entry valid/ready FIFO of 37-bit entries holding pointers and count.
- HI/LO, flag and sticky registers stay in the top level.

## Test plan
- **Reset:** hold reset low with alu_valid=1. Then HI=LO=0, flags=0, wb_valid=0, alu_ready=1, pending=0.
- **MUL capture:** FS=5'h1E, Y_Hi=32'h0000_0001, Y_Low=32'hFFFF_FFFE, flags 4'b0000.
  - Next cycle: HI=1, LO=32'hFFFF_FFFE.
  - No writeback: wb_valid stays 0.
- **ADDU writeback:** FS=5'h03, dest=5'd8, Y_Low=32'h0000_0010, wb_ready=1.
  - Next cycle: wb_valid=1, wb_addr=8, wb_data=32'h10.
  - Following cycle: pending=0.
- **Backpressure and order:** wb_ready=0; push dest 3 (data 32'hA), then dest 4 (data 32'hB).
  - pending=2, alu_ready=0.
  - A third alu_valid is not accepted.
  - Raise wb_ready: entries drain in order 3 then 4.
  - Simultaneous push+pop at pending=1 keeps pending=1.
- **R0 drop:** FS=5'h03, dest=0, Z=1. Then no push (pending unchanged) and flags=4'b0100.
- **Sticky overflow:** accepted result with V=1 sets ovf_sticky.
  - clr_sticky together with a V=1 result: ovf_sticky stays 1.
  - clr_sticky with V=0: ovf_sticky goes to 0.
  - Asserting reset with 2 queued entries clears pending to 0 immediately (asynchronously).
